// File: rtl/capi_command_scheduler_pkg.sv
// Shared widths and types for the PSL command scheduler.
// Command fields are fixed by the PSL interface; credits are a 9-bit signed count.
package capi_command_scheduler_pkg;
   localparam int CMD_W     = 13;
   localparam int TAG_W     = 8;
   localparam int ADDR_W    = 64;
   localparam int SIZE_W    = 12;
   localparam int CREDIT_W  = 9;
   localparam int REQ_IDX_W = 3;

   typedef logic [TAG_W-1:0]            tag_t;
   typedef logic [REQ_IDX_W-1:0]        req_idx_t;
   typedef logic signed [CREDIT_W-1:0]  credit_t;
endpackage

// File: rtl/capi_command_scheduler_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant.
module round_robin_arbiter
   import capi_command_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] request,
   input  req_idx_t           last_grant,
   output logic [NUM_REQ-1:0] grant,
   output req_idx_t           grant_index
);

   int   idx;
   logic found;

   always_comb begin
      grant       = '0;
      grant_index = last_grant;
      found       = 1'b0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && request[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_index = req_idx_t'(idx);
         end
      end
   end

endmodule

// File: rtl/capi_command_scheduler.sv
// Shares the PSL command port between NUM_REQ requesters: tag pool, credit
// tracking, round-robin grant, registered command and response-owner outputs.
module capi_command_scheduler
   import capi_command_scheduler_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_TAGS = 32
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [7:0]                  croom,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*CMD_W-1:0]    req_command,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
   input  logic [NUM_REQ*SIZE_W-1:0]   req_size,
   output logic [NUM_REQ-1:0]          req_ready,
   output tag_t                        req_tag,
   output logic                        command_valid,
   output logic [CMD_W-1:0]            command_command,
   output tag_t                        command_tag,
   output logic [ADDR_W-1:0]           command_address,
   output logic [SIZE_W-1:0]           command_size,
   input  logic                        response_valid,
   input  tag_t                        response_tag,
   input  logic signed [CREDIT_W-1:0]  response_credits,
   output logic                        response_owner_valid,
   output req_idx_t                    response_owner,
   output credit_t                     credits,
   output logic                        idle,
   output logic                        error
);

   localparam int TIDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

   logic [NUM_TAGS-1:0]   in_use;
   req_idx_t              owner [NUM_TAGS];
   credit_t               credits_q;
   req_idx_t              last_grant;
   logic                  error_q;

   logic [NUM_REQ-1:0]    grant;
   req_idx_t              grant_index;
   logic [TIDX_W-1:0]     free_index;
   logic                  any_free;
   logic                  can_issue;
   logic                  issue;
   logic [TIDX_W-1:0]     resp_index;
   logic                  resp_hit;
   logic signed [10:0]    credit_sum;
   credit_t               credit_next;
   logic                  overflow;

   round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
      .request     (req_valid),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_index (grant_index)
   );

   // Lowest free tag wins; scanning downward leaves the smallest index last.
   always_comb begin
      free_index = '0;
      any_free   = 1'b0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!in_use[i]) begin
            free_index = TIDX_W'(i);
            any_free   = 1'b1;
         end
      end
   end

   assign can_issue = (credits_q > 9'sd0) && any_free && !start;
   assign req_ready = can_issue ? grant : '0;
   assign req_tag   = tag_t'(free_index);
   assign issue     = can_issue && (|req_valid);

   // Out-of-range tags are screened before the bitmap lookup is trusted.
   assign resp_index = response_tag[TIDX_W-1:0];
   assign resp_hit   = response_valid && (int'(response_tag) < NUM_TAGS) && in_use[resp_index];

   always_comb begin
      credit_sum = {{2{credits_q[CREDIT_W-1]}}, credits_q} - {10'd0, issue}
                 + (response_valid ? {{2{response_credits[CREDIT_W-1]}}, response_credits} : 11'sd0);
      overflow    = 1'b0;
      credit_next = credit_sum[CREDIT_W-1:0];
      if (credit_sum > 11'sd255) begin
         credit_next = 9'sd255;
         overflow    = 1'b1;
      end else if (credit_sum < -11'sd256) begin
         credit_next = -9'sd256;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         in_use               <= '0;
         credits_q            <= '0;
         last_grant           <= req_idx_t'(NUM_REQ - 1);
         error_q              <= 1'b0;
         command_valid        <= 1'b0;
         command_command      <= '0;
         command_tag          <= '0;
         command_address      <= '0;
         command_size         <= '0;
         response_owner_valid <= 1'b0;
         response_owner       <= '0;
      end else if (start) begin
         credits_q            <= {1'b0, croom};
         in_use               <= '0;
         last_grant           <= req_idx_t'(NUM_REQ - 1);
         error_q              <= 1'b0;
         command_valid        <= 1'b0;
         response_owner_valid <= 1'b0;
      end else begin
         command_valid        <= issue;
         response_owner_valid <= resp_hit;
         credits_q            <= credit_next;
         if (issue) begin
            in_use[free_index] <= 1'b1;
            owner[free_index]  <= grant_index;
            last_grant         <= grant_index;
            command_command    <= req_command[grant_index*CMD_W +: CMD_W];
            command_address    <= req_address[grant_index*ADDR_W +: ADDR_W];
            command_size       <= req_size[grant_index*SIZE_W +: SIZE_W];
            command_tag        <= tag_t'(free_index);
         end
         // The freed tag is never the one being issued, so both updates stand.
         if (resp_hit) begin
            in_use[resp_index] <= 1'b0;
            response_owner     <= owner[resp_index];
         end
         if ((response_valid && !resp_hit) || overflow) error_q <= 1'b1;
      end
   end

   assign credits = credits_q;
   assign error   = error_q;
   assign idle    = ~(|in_use) & ~(|req_valid);

endmodule

// File: tb/tb_capi_command_scheduler.sv
// Bench for capi_command_scheduler: directed scenarios then random traffic,
// all checked against a tag-pool/credit reference model held in plain variables.
module tb_capi_command_scheduler;
   localparam int NR = 4;
   localparam int NT = 8;

   logic               clock = 1'b0;
   logic               reset_n;
   logic               start;
   logic [7:0]         croom;
   logic [NR-1:0]      req_valid;
   logic [NR*13-1:0]   req_command;
   logic [NR*64-1:0]   req_address;
   logic [NR*12-1:0]   req_size;
   logic [NR-1:0]      req_ready;
   logic [7:0]         req_tag;
   logic               command_valid;
   logic [12:0]        command_command;
   logic [7:0]         command_tag;
   logic [63:0]        command_address;
   logic [11:0]        command_size;
   logic               response_valid;
   logic [7:0]         response_tag;
   logic signed [8:0]  response_credits;
   logic               response_owner_valid;
   logic [2:0]         response_owner;
   logic signed [8:0]  credits;
   logic               idle;
   logic               error;

   capi_command_scheduler #(.NUM_REQ(NR), .NUM_TAGS(NT)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .croom(croom),
      .req_valid(req_valid), .req_command(req_command), .req_address(req_address),
      .req_size(req_size), .req_ready(req_ready), .req_tag(req_tag),
      .command_valid(command_valid), .command_command(command_command),
      .command_tag(command_tag), .command_address(command_address),
      .command_size(command_size), .response_valid(response_valid),
      .response_tag(response_tag), .response_credits(response_credits),
      .response_owner_valid(response_owner_valid), .response_owner(response_owner),
      .credits(credits), .idle(idle), .error(error)
   );

   always #5 clock = ~clock;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: which tags are outstanding, who owns them, credit count.
   bit          m_used [NT];
   int          m_owner [NT];
   int          m_credits;
   int          m_last;
   bit          m_err;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic int m_free();
      for (int i = 0; i < NT; i++) if (!m_used[i]) return i;
      return -1;
   endfunction

   function automatic int m_pick_used();
      int q[$];
      for (int i = 0; i < NT; i++) if (m_used[i]) q.push_back(i);
      if (q.size() == 0) return -1;
      return q[$urandom_range(0, q.size() - 1)];
   endfunction

   function automatic bit m_all_free();
      for (int i = 0; i < NT; i++) if (m_used[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NT; i++) begin m_used[i] = 1'b0; m_owner[i] = 0; end
      m_last = NR - 1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; req_valid = '0; response_valid = 1'b0;
      @(posedge clock); #1;
      model_clear(); m_credits = 0; m_err = 1'b0;
      chk("rst_command_valid", command_valid, 0);
      chk("rst_command_command", command_command, 0);
      chk("rst_command_tag", command_tag, 0);
      chk("rst_command_address", command_address, 0);
      chk("rst_command_size", command_size, 0);
      chk("rst_owner_valid", response_owner_valid, 0);
      chk("rst_owner", response_owner, 0);
      chk("rst_credits", {55'd0, credits}, 0);
      chk("rst_error", error, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_idle", idle, 1);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // One clock: drive inputs, check grant outputs, advance model, check registers.
   task automatic cycle(input bit st, input logic [7:0] cr, input logic [NR-1:0] rv,
                        input bit rspv, input logic [7:0] rt, input int rc);
      int g, ft, idx, nc;
      bit hit, e_cv, e_rov;
      logic [12:0] e_cmd; logic [63:0] e_addr; logic [11:0] e_size; logic [7:0] e_tag;
      logic [2:0] e_owner;
      start = st; croom = cr; req_valid = rv;
      response_valid = rspv; response_tag = rt; response_credits = 9'(rc);
      for (int r = 0; r < NR; r++) begin
         req_command[r*13 +: 13] = 13'($urandom);
         req_address[r*64 +: 64] = {$urandom, $urandom};
         req_size[r*12 +: 12]    = 12'($urandom);
      end
      #1;
      g = -1; ft = m_free();
      if (!st && m_credits > 0 && ft >= 0)
         for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (g < 0 && rv[idx]) g = idx;
         end
      chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) chk("req_tag", req_tag, ft);
      chk("idle", idle, (m_all_free() && rv == '0) ? 1 : 0);

      e_cv = 1'b0; e_rov = 1'b0; e_cmd = '0; e_addr = '0; e_size = '0; e_tag = '0; e_owner = '0;
      if (st) begin
         model_clear(); m_credits = cr; m_err = 1'b0;
      end else begin
         hit = rspv && (rt < NT) && m_used[rt];
         if (g >= 0) begin
            e_cv = 1'b1; e_tag = 8'(ft);
            e_cmd  = req_command[g*13 +: 13];
            e_addr = req_address[g*64 +: 64];
            e_size = req_size[g*12 +: 12];
            m_used[ft] = 1'b1; m_owner[ft] = g; m_last = g;
         end
         if (hit) begin
            e_rov = 1'b1; e_owner = 3'(m_owner[rt]); m_used[rt] = 1'b0;
         end
         if (rspv && !hit) m_err = 1'b1;
         nc = m_credits - ((g >= 0) ? 1 : 0) + (rspv ? rc : 0);
         if (nc > 255) begin nc = 255; m_err = 1'b1; end
         else if (nc < -256) nc = -256;
         m_credits = nc;
      end

      @(posedge clock); #1;
      chk("command_valid", command_valid, e_cv);
      if (e_cv) begin
         chk("command_command", command_command, e_cmd);
         chk("command_tag", command_tag, e_tag);
         chk("command_address", command_address, e_addr);
         chk("command_size", command_size, e_size);
      end
      chk("owner_valid", response_owner_valid, e_rov);
      if (e_rov) chk("owner", response_owner, e_owner);
      chk("credits", {55'd0, credits}, {55'd0, 9'(m_credits)});
      chk("error", error, m_err);
      @(negedge clock);
   endtask

   task automatic drain();
      int t;
      for (int n = 0; n < NT; n++) begin
         t = m_pick_used();
         if (t >= 0) cycle(0, 0, '0, 1, 8'(t), 1);
      end
   endtask

   initial begin
      int t;
      bit rspv;
      logic [7:0] rt;
      reset_n = 1'b0; start = 1'b0; croom = '0; req_valid = '0;
      req_command = '0; req_address = '0; req_size = '0;
      response_valid = 1'b0; response_tag = '0; response_credits = '0;
      @(negedge clock);
      do_reset();

      // Two credits: tags 0 and 1 go back to back, third stalls until credit returns.
      cycle(1, 8'd2, 4'b0001, 0, 0, 0);
      repeat (3) cycle(0, 0, 4'b0001, 0, 0, 0);
      cycle(0, 0, 4'b0001, 1, 8'd0, 1);
      cycle(0, 0, 4'b0001, 0, 0, 0);
      drain();

      // Round-robin with all requesters asserting and responses recycling tags.
      cycle(1, 8'd200, 4'b1111, 0, 0, 0);
      repeat (12) begin
         t = m_pick_used();
         cycle(0, 0, 4'b1111, t >= 0, 8'(t), 1);
      end
      drain();

      // Tag exhaustion, then tag 2 freed and reused one cycle later.
      cycle(1, 8'd16, 4'b0001, 0, 0, 0);
      repeat (10) cycle(0, 0, 4'b0001, 0, 0, 0);
      cycle(0, 0, 4'b0001, 1, 8'd2, 0);
      cycle(0, 0, 4'b0001, 0, 0, 0);

      // Credits = 1 with simultaneous issue and +1 response for tag 3.
      cycle(1, 8'd5, 4'b0100, 0, 0, 0);
      repeat (4) cycle(0, 0, 4'b0100, 0, 0, 0);
      cycle(0, 0, 4'b0010, 1, 8'd3, 1);

      // Error paths: free tag, out-of-range tag, credit overflow, cleared by start.
      cycle(0, 0, '0, 1, 8'd7, 0);
      cycle(0, 0, '0, 1, 8'd9, 0);
      cycle(0, 0, '0, 1, 8'd0, 255);
      cycle(1, 8'd10, '0, 0, 0, 0);

      // Reset with three tags outstanding discards them.
      repeat (3) cycle(0, 0, 4'b1000, 0, 0, 0);
      do_reset();
      cycle(1, 8'd4, '0, 0, 0, 0);
      cycle(0, 0, 4'b0010, 0, 0, 0);
      cycle(0, 0, '0, 1, 8'd2, 0);

      // Random traffic.
      cycle(1, 8'd20, '0, 0, 0, 0);
      repeat (400) begin
         rspv = ($urandom_range(0, 1) == 1);
         t = m_pick_used();
         rt = (t >= 0 && $urandom_range(0, 9) != 0) ? 8'(t) : 8'($urandom_range(0, 9));
         cycle($urandom_range(0, 99) == 0, 8'($urandom_range(0, 12)), 4'($urandom),
               rspv, rt, ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
